// File: rtl/ibex_multdiv_arbiter.sv
// rtl/ibex_multdiv_arbiter.sv - round-robin front end sharing one slow multdiv unit between two requesters
//
// Purpose:
//   Two requesters (0 = core ID stage, 1 = auxiliary port) compete for a single
//   iterative multiply/divide unit. The winner's operands are latched for the
//   whole operation, the unit is driven from those latches, its result is
//   captured and handed back to the owner on a valid/ready response channel.
//   A watchdog bounds the time spent waiting for the unit.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester request handshake (ready is the grant)
//   req_op_i, req_signed_i  per-requester operator and signed mode
//   req_a_i, req_b_i        per-requester operands
//   rsp_valid_o/rsp_ready_i per-requester response handshake
//   rsp_result_o            shared result bus, meaningful where rsp_valid_o is set
//   md_*_o                  enables, selects, operator, signed mode, operands to the unit
//   md_ready_id_o           result-accept to the unit
//   md_valid_i, md_result_i unit completion and result
//   data_ind_timing_o       static DataIndTiming
//   timeout_o               one-cycle pulse when the watchdog fires
//   busy_o                  arbiter is not idle
//
// TimeoutCycles must lie in 40..255 so the cycle counter fits in 8 bits.
module ibex_multdiv_arbiter #(
   parameter bit          DataIndTiming = 1'b0,
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic [1:0]       req_valid_i,
   output logic [1:0]       req_ready_o,
   input  logic [1:0][1:0]  req_op_i,
   input  logic [1:0][1:0]  req_signed_i,
   input  logic [1:0][31:0] req_a_i,
   input  logic [1:0][31:0] req_b_i,

   output logic [1:0]       rsp_valid_o,
   input  logic [1:0]       rsp_ready_i,
   output logic [31:0]      rsp_result_o,

   output logic             md_mult_en_o,
   output logic             md_div_en_o,
   output logic             md_mult_sel_o,
   output logic             md_div_sel_o,
   output logic [1:0]       md_operator_o,
   output logic [1:0]       md_signed_mode_o,
   output logic [31:0]      md_op_a_o,
   output logic [31:0]      md_op_b_o,
   output logic             data_ind_timing_o,
   output logic             md_ready_id_o,
   input  logic             md_valid_i,
   input  logic [31:0]      md_result_i,

   output logic             timeout_o,
   output logic             busy_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

   logic [1:0]  state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;     // requester favoured when both are valid
   logic        owner_q, owner_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  sm_q, sm_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] result_q, result_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   logic        in_idle, in_busy, in_resp;
   logic        winner;
   logic        grant;
   logic        timeout_hit;
   logic        unit_run;

   assign in_idle = (state_q == ST_IDLE);
   assign in_busy = (state_q == ST_BUSY);
   assign in_resp = (state_q == ST_RESP);

   // A lone requester wins outright; a tie goes to the round-robin pointer.
   always_comb begin
      winner = req_valid_i[1];
      if (req_valid_i == 2'b11) begin
         winner = rr_ptr_q;
      end
   end

   // Ready is only ever raised towards a requester that is valid, so the
   // grant itself is the handshake. Reset masks it so nothing is latched.
   assign grant = in_idle && (|req_valid_i) && !rst_i;

   // Out of time with no completion: the unit is released from enable in the
   // deciding cycle so it stays frozen from here on.
   assign timeout_hit = in_busy && (cnt_q == CntLast) && !md_valid_i;
   assign unit_run    = in_busy && !timeout_hit;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      op_d      = op_q;
      sm_d      = sm_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               owner_d  = winner;
               op_d     = req_op_i[winner];
               sm_d     = req_signed_i[winner];
               a_d      = req_a_i[winner];
               b_d      = req_b_i[winner];
               rr_ptr_d = ~winner;
               cnt_d    = 8'd0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (md_valid_i) begin
               result_d = md_result_i;
               state_d  = ST_RESP;
            end else if (timeout_hit) begin
               result_d  = 32'hFFFF_FFFF;
               timeout_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= 1'b0;
         owner_q   <= 1'b0;
         op_q      <= 2'd0;
         sm_q      <= 2'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         result_q  <= 32'd0;
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         op_q      <= op_d;
         sm_q      <= sm_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign req_ready_o = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;

   assign rsp_valid_o  = in_resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result_o = in_resp ? result_q : 32'd0;

   // op[1] separates the divider operators (DIV/REM) from the multiplier ones.
   assign md_mult_en_o  = unit_run && !op_q[1];
   assign md_mult_sel_o = unit_run && !op_q[1];
   assign md_div_en_o   = unit_run && op_q[1];
   assign md_div_sel_o  = unit_run && op_q[1];

   assign md_operator_o     = op_q;
   assign md_signed_mode_o  = sm_q;
   assign md_op_a_o         = a_q;
   assign md_op_b_o         = b_q;
   assign data_ind_timing_o = DataIndTiming;
   assign md_ready_id_o     = in_busy;

   assign timeout_o = timeout_q;
   assign busy_o    = !in_idle;

endmodule
